h264dc_transform_arbiter: RTL

//  Shares the single DC Hadamard transform core among NREQ requesters (default: luma Intra16x16 DC, Cb DC, Cr DC).

---
 rtl/h264dc_transform_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/h264dc_transform_arbiter.sv
// h264dc_transform_arbiter
// Shares one DC Hadamard transform core among NREQ requesters. Whole blocks of
// BEATS rows are granted round-robin and fed to the core. Each block's owner is
// queued in a small in-order tag FIFO, so that returning core rows can be
// steered back to that owner.
module h264dc_transform_arbiter #(
    parameter int NREQ  = 3,
    parameter int DW    = 64,
    parameter int BEATS = 4,
    parameter int TAGQ  = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ-1:0]      IN_VALID,
    input  logic [NREQ*DW-1:0]   IN_DATA,
    output logic [NREQ-1:0]      GRANT,
    output logic                 XFM_EN,
    output logic [DW-1:0]        XFM_DIN,
    input  logic                 XFM_OVALID,
    input  logic [DW-1:0]        XFM_DOUT,
    output logic [NREQ-1:0]      OUT_VALID,
    output logic [DW-1:0]        OUT_DATA,
    output logic                 OUT_LAST,
    output logic                 BUSY,
    output logic                 ERR
);

    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CANDW = IW + 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = (TAGQ > 1) ? $clog2(TAGQ) : 1;
    localparam int QW    = $clog2(TAGQ + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic {IDLE, FEED} state_t;

    state_t            state;
    logic [NREQ-1:0]   grant_r;
    logic [IW-1:0]     gidx;
    logic [IW-1:0]     rr_ptr;
    logic [CW-1:0]     in_cnt;
    logic [CW-1:0]     out_cnt;
    logic [IW-1:0]     tag_mem [TAGQ];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [QW-1:0]     fifo_count;
    logic              err_r;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [CANDW-1:0]  cand;
    logic              fifo_full;
    logic              fifo_empty;
    logic              last_in;
    logic              push_ok;
    logic              pop;
    logic [IW-1:0]     head_tag;

    // Round-robin search: first requester at or after rr_ptr, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + CANDW'(i);
            if (cand >= CANDW'(NREQ)) begin
                cand = cand - CANDW'(NREQ);
            end
            if (!pick_found && REQ[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // Core-side and owner-side steering; the returning path has no backpressure
    always_comb begin
        fifo_full  = (fifo_count == QW'(TAGQ));
        fifo_empty = (fifo_count == '0);
        head_tag   = tag_mem[rd_ptr];
        XFM_EN     = (state == FEED) && IN_VALID[gidx];
        XFM_DIN    = (state == FEED) ? IN_DATA[gidx*DW +: DW] : '0;
        last_in    = XFM_EN && (in_cnt == LAST_BEAT);
        pop        = XFM_OVALID && !fifo_empty && (out_cnt == LAST_BEAT);
        push_ok    = last_in && (!fifo_full || pop);
        OUT_VALID  = (XFM_OVALID && !fifo_empty) ? (NREQ'(1) << head_tag) : '0;
        OUT_DATA   = XFM_DOUT;
        OUT_LAST   = pop;
        BUSY       = (state == FEED) || !fifo_empty;
        GRANT      = grant_r;
        ERR        = err_r;
    end

    // Grant FSM: grant a whole block, count accepted rows, then release with one idle bubble
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            grant_r <= '0;
            gidx    <= '0;
            rr_ptr  <= '0;
            in_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found && !fifo_full) begin
                        grant_r <= NREQ'(1) << pick_idx;
                        gidx    <= pick_idx;
                        state   <= FEED;
                    end
                end
                FEED: begin
                    if (XFM_EN) begin
                        if (in_cnt == LAST_BEAT) begin
                            in_cnt  <= '0;
                            grant_r <= '0;
                            state   <= IDLE;
                            rr_ptr  <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag FIFO: owner index pushed on a block's last input row, popped on its last output row
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < TAGQ; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                tag_mem[wr_ptr] <= gidx;
                wr_ptr <= (wr_ptr == PW'(TAGQ - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(TAGQ - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push_ok && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Output row counter, plus sticky error for core rows that have no owner
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_cnt <= '0;
            err_r   <= 1'b0;
        end else if (XFM_OVALID) begin
            if (fifo_empty) begin
                err_r <= 1'b1;
            end else if (out_cnt == LAST_BEAT) begin
                out_cnt <= '0;
            end else begin
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

endmodule
